// File: rtl/phase_search_pkg.sv
// phase_search_pkg: shared state encoding, default constants and counter sizing for phase_search_ctrl
package phase_search_pkg;
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, EVAL, LOCKED, FAIL} state_t;
  localparam int DEF_PHASE_W = 32;
  localparam logic [31:0] DEF_PHASE_STEP = 32'h0800_0000;
  localparam int DEF_SETTLE_CYC = 80;
  localparam int DEF_EVAL_CYC = 64;
  localparam int DEF_LOCK_CNT = 16;
  localparam int DEF_LOSS_CNT = 8;
  localparam int DEF_MAX_STEPS = 16;
  function automatic int cnt_w(input int v);
    return $clog2(v + 1);
  endfunction
endpackage

// File: rtl/phase_search_runlen.sv
// phase_search_runlen: saturating consecutive-run counter of bit_in==pol with clear and terminal flag
module phase_search_runlen import phase_search_pkg::*; #(
  parameter int LIMIT = 4,
  parameter int W = cnt_w(LIMIT)
) (
  input  logic clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic pol,
  input  logic bit_in,
  output logic term
);
  logic [W-1:0] cnt;
  assign term = cnt == W'(LIMIT);
  always_ff @(posedge clk)
    if (sys_rst || clr) cnt <= '0;
    else cnt <= (bit_in != pol) ? '0 : term ? cnt : cnt + 1'b1;
endmodule

// File: rtl/phase_search_ctrl.sv
// phase_search_ctrl: steps DDS phase offset until lock detector holds; PHASE_SEARCH_BIDIR_EN selects alternating probes around P0
module phase_search_ctrl import phase_search_pkg::*; #(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter logic [PHASE_W-1:0] PHASE_STEP = PHASE_W'(DEF_PHASE_STEP),
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int EVAL_CYC = DEF_EVAL_CYC,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int LOSS_CNT = DEF_LOSS_CNT,
  parameter int MAX_STEPS = DEF_MAX_STEPS
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               adjust_in,
  output logic [PHASE_W-1:0] phase_ofs,
  output logic               ofs_valid,
  output logic               searching,
  output logic               locked,
  output logic               lost_pulse,
  output logic               sweep_fail
);
  localparam int SW = cnt_w(SETTLE_CYC);
  localparam int WW = cnt_w(EVAL_CYC);
  localparam int TW = cnt_w(MAX_STEPS);
  state_t state;
  logic [SW-1:0] settle_cnt;
  logic [WW-1:0] win_cnt;
  logic [TW-1:0] step_cnt;
  logic [PHASE_W-1:0] next_ofs, restart_ofs;
  logic hit_term, miss_term;
  phase_search_runlen #(.LIMIT(LOCK_CNT)) u_hit (
    .clk(clk), .sys_rst(sys_rst), .clr(state != EVAL), .pol(1'b1), .bit_in(adjust_in), .term(hit_term)
  );
  phase_search_runlen #(.LIMIT(LOSS_CNT)) u_miss (
    .clk(clk), .sys_rst(sys_rst), .clr(state != LOCKED), .pol(1'b0), .bit_in(adjust_in), .term(miss_term)
  );
`ifdef PHASE_SEARCH_BIDIR_EN
  logic [PHASE_W-1:0] p0, delta;
  logic [TW-1:0] nxt, mag;
  always_comb begin
    nxt = step_cnt + 1'b1;
    mag = (nxt >> 1) + TW'(nxt[0]);
    delta = PHASE_W'(mag) * PHASE_STEP;
    next_ofs = nxt[0] ? p0 + delta : p0 - delta;
  end
  assign restart_ofs = phase_ofs;
  always_ff @(posedge clk)
    if (sys_rst) p0 <= '0;
    else if ((start && (state == IDLE || state == FAIL)) || (state == LOCKED && miss_term)) p0 <= phase_ofs;
`else
  assign next_ofs = phase_ofs + PHASE_STEP;
  assign restart_ofs = next_ofs;
`endif
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state <= IDLE;
      phase_ofs <= '0;
      ofs_valid <= 1'b0;
      searching <= 1'b0;
      locked <= 1'b0;
      lost_pulse <= 1'b0;
      sweep_fail <= 1'b0;
      settle_cnt <= '0;
      win_cnt <= '0;
      step_cnt <= '0;
    end else begin
      ofs_valid <= 1'b0;
      lost_pulse <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= APPLY;
          step_cnt <= '0;
          ofs_valid <= 1'b1;
          searching <= 1'b1;
        end
        APPLY: begin
          state <= SETTLE;
          settle_cnt <= '0;
        end
        SETTLE: if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
          state <= EVAL;
          win_cnt <= '0;
        end else settle_cnt <= settle_cnt + 1'b1;
        EVAL: if (hit_term) begin
          state <= LOCKED;
          locked <= 1'b1;
          searching <= 1'b0;
        end else if (win_cnt == WW'(EVAL_CYC - 1)) begin
          if (step_cnt == TW'(MAX_STEPS - 1)) begin
            state <= FAIL;
            sweep_fail <= 1'b1;
            searching <= 1'b0;
          end else begin
            state <= APPLY;
            ofs_valid <= 1'b1;
            step_cnt <= step_cnt + 1'b1;
            phase_ofs <= next_ofs;
          end
        end else win_cnt <= win_cnt + 1'b1;
        LOCKED: if (miss_term) begin
          state <= EVAL;
          locked <= 1'b0;
          lost_pulse <= 1'b1;
          searching <= 1'b1;
          step_cnt <= '0;
          win_cnt <= '0;
        end
        FAIL: if (start) begin
          state <= APPLY;
          sweep_fail <= 1'b0;
          searching <= 1'b1;
          ofs_valid <= 1'b1;
          step_cnt <= '0;
          phase_ofs <= restart_ofs;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_phase_search_ctrl.sv
// tb_phase_search_ctrl: directed and randomized checks of phase_search_ctrl against a queue-based reference model
module tb_phase_search_ctrl;
  localparam logic [31:0] STEP = 32'h0800_0000;
  localparam int SETTLE = 8, EVAL = 20, LOCK = 4, LOSS = 3, MAXS = 16;
  logic clk = 0, sys_rst = 1, start = 0, adjust_in = 0;
  logic [31:0] phase_ofs;
  logic ofs_valid, searching, locked, lost_pulse, sweep_fail;
  phase_search_ctrl #(
    .PHASE_W(32), .PHASE_STEP(STEP), .SETTLE_CYC(SETTLE), .EVAL_CYC(EVAL),
    .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .MAX_STEPS(MAXS)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .adjust_in(adjust_in), .phase_ofs(phase_ofs),
    .ofs_valid(ofs_valid), .searching(searching), .locked(locked), .lost_pulse(lost_pulse), .sweep_fail(sweep_fail)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  bit armed = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t: got %h, expected %h", nm, $time, act, exp);
  endtask
  typedef enum {M_IDLE, M_APPLY, M_SETTLE, M_EVAL, M_LOCKED, M_FAIL} mode_t;
  mode_t m = M_IDLE;
  int age = 0, steps = 0;
  bit hist[$];
  logic [31:0] e_ofs = 0;
  logic e_valid = 0, e_lost = 0;
  function automatic bit tail_all(input bit v, input int n);
    if (hist.size() < n) return 0;
    for (int i = hist.size() - n; i < hist.size(); i++) if (hist[i] != v) return 0;
    return 1;
  endfunction
  always @(posedge clk) begin
    if (sys_rst) begin
      m = M_IDLE; e_ofs = 0; e_valid = 0; e_lost = 0; steps = 0; age = 0; hist.delete();
    end else begin
      e_valid = 0;
      e_lost = 0;
      case (m)
        M_IDLE: if (start) begin m = M_APPLY; steps = 0; e_valid = 1; end
        M_APPLY: begin m = M_SETTLE; age = 0; end
        M_SETTLE: begin age++; if (age == SETTLE) begin m = M_EVAL; hist.delete(); end end
        M_EVAL:
          if (tail_all(1, LOCK)) begin m = M_LOCKED; hist.delete(); end
          else if (hist.size() == EVAL - 1) begin
            if (steps == MAXS - 1) m = M_FAIL;
            else begin steps++; e_ofs += STEP; m = M_APPLY; e_valid = 1; end
          end else hist.push_back(adjust_in);
        M_LOCKED:
          if (tail_all(0, LOSS)) begin m = M_EVAL; e_lost = 1; steps = 0; hist.delete(); end
          else hist.push_back(adjust_in);
        M_FAIL: if (start) begin m = M_APPLY; e_ofs += STEP; steps = 0; e_valid = 1; end
        default: m = M_IDLE;
      endcase
    end
  end
  wire logic [36:0] act_v = {ofs_valid, searching, locked, lost_pulse, sweep_fail, phase_ofs};
  wire logic [36:0] exp_v = {e_valid, m inside {M_APPLY, M_SETTLE, M_EVAL}, m == M_LOCKED, e_lost, m == M_FAIL, e_ofs};
  always @(negedge clk) if (armed) chk("cycle_outputs", 64'(act_v), 64'(exp_v));
  int adj_mode = 0, adj_pct = 50, pat = 0;
  logic adj_man = 0;
  task automatic tick();
    @(negedge clk);
    case (adj_mode)
      0: adjust_in = adj_man;
      1: adjust_in = ($urandom_range(99) < adj_pct);
      2: adjust_in = (phase_ofs == 32'h1800_0000);
      default: begin adjust_in = (pat % 4) != 3; pat++; end
    endcase
  endtask
  task automatic drive(input logic v);
    adj_man = v;
    adjust_in = v;
  endtask
  task automatic do_reset();
    sys_rst = 1;
    tick();
    tick();
    sys_rst = 0;
  endtask
  int cyc, pulses;
  bit seen_lock;
  task automatic run_until_lock(input int limit);
    start = 1; cyc = 0; pulses = 0;
    do begin
      tick(); cyc++; start = 0;
      pulses += int'(ofs_valid);
    end while (!locked && cyc < limit);
  endtask
  task automatic run_until_fail(input int limit);
    start = 1; cyc = 0; seen_lock = 0;
    do begin
      tick(); cyc++; start = 0;
      seen_lock |= locked;
    end while (!sweep_fail && cyc < limit);
  endtask
  initial begin
    @(posedge clk);
    armed = 1;
    tick();
    tick();
    chk("reset_outputs", 64'(act_v), 64'd0);
    sys_rst = 0;
    drive(1);
    tick();
    start = 1;
    tick();
    start = 0;
    chk("first_ofs_valid", {ofs_valid, phase_ofs}, {1'b1, 32'h0});
    repeat (13) tick();
    chk("locked_before", locked, 0);
    tick();
    chk("locked_at_14", {locked, phase_ofs}, {1'b1, 32'h0});
    chk("model_locked_at_14", m == M_LOCKED, 1);
    drive(0);
    tick();
    tick();
    drive(1);
    tick();
    chk("short_miss_stays_locked", locked, 1);
    drive(0);
    repeat (3) tick();
    chk("before_loss", {lost_pulse, locked}, 2'b01);
    tick();
    chk("loss_pulse", {lost_pulse, locked, searching, phase_ofs}, {3'b101, 32'h0});
    tick();
    chk("loss_pulse_single", lost_pulse, 0);
    do_reset();
    adj_mode = 2;
    tick();
    run_until_lock(2000);
    chk("target_lock_cycles", cyc, 102);
    chk("target_lock_ofs", phase_ofs, 32'h1800_0000);
    chk("target_probe_count", pulses, 4);
    chk("model_target_ofs", e_ofs, 32'h1800_0000);
    do_reset();
    adj_mode = 3;
    tick();
    run_until_fail(2000);
    chk("pattern_fail_cycles", cyc, 465);
    chk("pattern_never_locked", seen_lock, 0);
    chk("pattern_fail_ofs", {sweep_fail, phase_ofs}, {1'b1, 32'h7800_0000});
    adj_mode = 0;
    drive(0);
    start = 1;
    tick();
    start = 0;
    chk("restart_ofs", {sweep_fail, ofs_valid, phase_ofs}, {2'b01, 32'h8000_0000});
    run_until_fail(2000);
    chk("second_fail_ofs", {sweep_fail, phase_ofs}, {1'b1, 32'hF800_0000});
    start = 1;
    tick();
    start = 0;
    chk("wrap_ofs", {ofs_valid, phase_ofs}, {1'b1, 32'h0});
    repeat (32) tick();
    chk("mid_settle_ofs", {searching, phase_ofs}, {1'b1, 32'h0800_0000});
    sys_rst = 1;
    tick();
    chk("reset_mid_settle", 64'(act_v), 64'd0);
    tick();
    sys_rst = 0;
    chk("reset_no_valid", ofs_valid, 0);
    adj_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) adj_pct = (i % 150 == 0) ? 95 : (i % 100 == 0) ? 20 : 60;
      tick();
      start = ($urandom_range(99) < 3);
      sys_rst = ($urandom_range(999) < 3);
    end
    start = 0;
    sys_rst = 0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/phase_search_ctrl.md
Name: phase_search_ctrl

Overview:
- Closes the loop around the correlation lock detector.
- Consumes the detector's 1-bit `adjust` flag and steps the phase offset word of the reference DDS until the correlation magnitude stays above threshold.
- Sits directly downstream of the detector and upstream of the reference DDS phase input.
- Reports lock, loss-of-lock and sweep failure to the top-level sequencer.

Parameters:
- PHASE_W, 32: width of phase offset word.
- PHASE_STEP, 32'h0800_0000: offset increment per probe (modulo 2^PHASE_W).
- SETTLE_CYC, 80: cycles ignored after each offset change. Covers the detector shift-register fill plus adder-tree latency.
- EVAL_CYC, 64: observation window per probe. Must be >= LOCK_CNT.
- LOCK_CNT, 16: consecutive `adjust_in` highs needed to declare lock.
- LOSS_CNT, 8: consecutive `adjust_in` lows in LOCKED needed to declare loss.
- MAX_STEPS, 16: probes before FAIL.

Ports:
- clk, in, 1: system clock.
- sys_rst, in, 1: synchronous reset, active-high.
- start, in, 1: single-cycle pulse. Honoured only in IDLE and FAIL.
- adjust_in, in, 1: lock-detector threshold flag.
- phase_ofs, out, PHASE_W: phase offset to DDS.
- ofs_valid, out, 1: one-cycle pulse when phase_ofs changes or is (re)applied.
- searching, out, 1: high in APPLY/SETTLE/EVAL.
- locked, out, 1: high in LOCKED.
- lost_pulse, out, 1: one-cycle pulse on LOCKED->EVAL.
- sweep_fail, out, 1: high in FAIL.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high on sys_rst, and has priority over all other inputs.
- Reset values:
  - State IDLE.
  - phase_ofs=0.
  - All outputs 0.
  - All counters 0.
- All outputs are registered.
- IDLE:
  - start -> APPLY, step_cnt=0.
  - phase_ofs unchanged, so a search begins from the last offset.
- APPLY:
  - One cycle; ofs_valid=1.
  - Next state SETTLE, settle_cnt=0.
- SETTLE:
  - adjust_in ignored.
  - After SETTLE_CYC cycles -> EVAL, win_cnt=0, hit_cnt=0.
- EVAL:
  - hit_cnt increments on adjust_in=1 and clears to 0 on adjust_in=0.
  - hit_cnt reaching LOCK_CNT -> LOCKED. locked rises on the following edge.
  - Lock takes priority over window expiry in the same cycle.
  - win_cnt reaching EVAL_CYC-1 without lock:
    - If step_cnt==MAX_STEPS-1 -> FAIL.
    - Otherwise phase_ofs <= phase_ofs+PHASE_STEP (wraps silently mod 2^PHASE_W), step_cnt+1, -> APPLY.
- LOCKED:
  - miss_cnt increments on adjust_in=0 and clears on 1.
  - miss_cnt reaching LOSS_CNT:
    - lost_pulse=1, locked=0, step_cnt=0, hit/win counters cleared.
    - Next state EVAL. The current offset is re-evaluated without SETTLE because it is unchanged.
  - start ignored.
- FAIL:
  - sweep_fail held.
  - start -> sweep_fail=0, step_cnt=0, phase_ofs advanced by PHASE_STEP, -> APPLY.
- start in APPLY/SETTLE/EVAL/LOCKED is ignored, with no queuing.
- Counter widths are $clog2(param+1). No counter may exceed its terminal value.
- Reset mid-search returns to IDLE with phase_ofs=0. No ofs_valid is emitted on reset.

Optional Feature:
- Macro PHASE_SEARCH_BIDIR_EN.
- Defined:
  - Probes alternate around the starting offset P0: P0+S, P0-S, P0+2S, P0-2S, ...
  - Each offset is computed from P0 and signed multiple k (k=±1,±2,…), not accumulated.
  - FAIL after MAX_STEPS probes.
  - Restart from FAIL sets P0 := current phase_ofs.
- Undefined: unidirectional accumulation as above.

Decomposition:
- Package phase_search_pkg: state enum (IDLE, APPLY, SETTLE, EVAL, LOCKED, FAIL), default parameter constants, counter-width function.
- One natural sub-module, phase_search_runlen: saturating consecutive-run counter with clear, polarity select and terminal flag. Instantiated twice, for hit and miss.

Test Plan:
All tests use PHASE_STEP=32'h0800_0000, SETTLE_CYC=8, EVAL_CYC=20, LOCK_CNT=4, LOSS_CNT=3, MAX_STEPS=16.
- Reset then start, adjust_in held 1:
  - ofs_valid one cycle later with phase_ofs=0.
  - locked=1 at 1+8+4+1 cycles after start.
  - phase_ofs stays 0.
- adjust_in=1 only while phase_ofs==32'h1800_0000:
  - Offsets step 0, 0800_0000, 1000_0000, 1800_0000.
  - locked asserts at the fourth probe with step_cnt=3.
- adjust_in pattern 1,1,1,0 repeating in EVAL: never locks. Verifies consecutive-run reset.
- adjust_in held 0:
  - After 16 probes, sweep_fail=1 with phase_ofs=32'h7800_0000.
  - Next start gives phase_ofs=32'h8000_0000 and sweep_fail=0.
- Start from phase_ofs=32'hF800_0000 with no lock: next probe phase_ofs=0 (wrap).
- In LOCKED, drive adjust_in=0 for 2 cycles then 1: stays locked. Drive 0 for 3 cycles: lost_pulse one cycle, locked=0, state EVAL, phase_ofs unchanged.
- sys_rst asserted mid-SETTLE: next cycle all outputs 0, no ofs_valid.
